psl_job_mmio_driver: RTL
========================

// Module: psl_job_mmio_driver
// PURPOSE
// - PSL-side (host-side) driver of the AFU control and MMIO interfaces; the initiator the AFU answers to.
// - Accepts one request at a time (job reset, job start, MMIO write, MMIO read), drives ha_j*/ha_mm* for one cycle.
// - Waits for the AFU response, then returns data and status on a valid/ready response port.
// - Sits in the simulation top and bring-up harness between the host command queue and the AFU.
// PARAMETERS
// - TIMEOUT_CYCLES  256  cycles waited for AFU response before status TIMEOUT; must be >= 2
// - CNT_W           9    timeout counter width; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
// - ha_pclock     in   1   clock; all logic on posedge
// - ha_reset      in   1   asynchronous active-high reset
// - req_valid     in   1   request present
// - req_ready     out  1   driver idle, request accepted when req_valid & req_ready
// - req_op        in   [0:1] 00 job reset, 01 job start, 10 MMIO write, 11 MMIO read
// - req_cfg       in   1   MMIO targets AFU descriptor space
// - req_dw        in   1   1 = doubleword, 0 = word
// - req_addr      in   [0:23] MMIO word address
// - req_data      in   [0:63] MMIO write data; also job effective address (ha_jea)
// - rsp_valid     out  1   response present, held until rsp_ready
// - rsp_ready     in   1   consumer accepts response
// - rsp_status    out  [0:1] 00 OK, 01 TIMEOUT, 10 PARITY_ERR
// - rsp_data      out  [0:63] MMIO read data (zero for other ops)
// - ha_jval, ha_jcom[0:7], ha_jcompar, ha_jea[0:63], ha_jeapar  out  job command to AFU
// - ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmad[0:23], ha_mmadpar,
//   ha_mmdata[0:63], ha_mmdatapar  out  MMIO request to AFU
// - ah_jrunning, ah_jdone, ah_mmack, ah_mmdata[0:63], ah_mmdatapar, ah_paren  in  AFU responses
// BEHAVIOUR
// - Reset: state IDLE; req_ready=1; rsp_valid=0; rsp_status=0; rsp_data=0; all ha_* outputs 0 (parity outputs included).
// - Parity is odd: parity bit = ~^field (field plus parity bit has an odd number of ones). Generated always.
// - States: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE: req_ready=1; on handshake capture request, req_ready drops next cycle, go ISSUE.
// - ISSUE (exactly 1 cycle): job ops: ha_jval=1, ha_jcom=0x80 (reset) or 0x90 (start), ha_jea=req_data.
//   MMIO ops: ha_mmval=1, ha_mmrnw=req_op[1]&req_op[0], ha_mmcfg/ha_mmdw/ha_mmad/ha_mmdata from request.
//   Next cycle ha_jval/ha_mmval return to 0; data fields may hold their values.
// - WAIT: counter cleared on entry, +1 per cycle. Completion: reset op -> ah_jdone=1; start op ->
//   ah_jrunning=1; MMIO -> ah_mmack=1. Response seen in the ISSUE cycle is ignored (earliest is first WAIT cycle).
// - Completion in the same cycle as counter==TIMEOUT_CYCLES-1: completion wins (OK).
// - No completion after TIMEOUT_CYCLES WAIT cycles: status TIMEOUT, rsp_data=0.
// - MMIO read, ah_paren=1, ah_mmdatapar != ~^ah_mmdata: status PARITY_ERR, rsp_data still = ah_mmdata.
// - MMIO read OK: rsp_data captured from ah_mmdata in the ah_mmack cycle; word reads return full 64 bits unmasked.
// - RESP: rsp_valid=1, outputs stable until rsp_ready; on handshake -> IDLE, req_ready=1 next cycle.
// - Stray ah_mmack/ah_jdone while IDLE or RESP: ignored, no state change.
// - ha_reset asserted mid-operation: immediate return to reset values; pending response is discarded.
// - Throughput: minimum 4 cycles per request (accept, issue, first-cycle ack, response handshake).
// STRUCTURE
// - psl_pkg: op encodings, job command constants JCOM_RESET=8'h80 and JCOM_START=8'h90,
//   status encodings, state enum.
// - One sub-module psl_timeout_counter (clear, enable, expired output; parameter TIMEOUT_CYCLES).
// - Parity helpers as functions in psl_pkg.
// TESTING
// - Job reset: op=00, AFU raises ah_jdone 3 cycles after ha_jval -> ha_jcom=0x80 for 1 cycle; rsp OK.
// - Job start: op=01 -> ha_jcom=0x90, ha_jcompar=1; ah_jrunning rises 1 cycle later -> rsp OK.
// - MMIO write: addr=0x000010, data=0xDEADBEEF_00000001, dw=1 -> ha_mmrnw=0; correct ha_mmadpar/ha_mmdatapar;
//   ack -> rsp OK, rsp_data=0.
// - MMIO read, paren=1: AFU returns 0x0123456789ABCDEF with correct parity -> OK, data matches;
//   flipped parity -> PARITY_ERR.
// - Timeout: TIMEOUT_CYCLES=16, AFU silent -> rsp TIMEOUT exactly 16 WAIT cycles after issue; next request accepted.
// - ha_reset asserted during WAIT, rsp_ready held low: all outputs return to reset values at once; no rsp_valid afterwards.

Source files
------------

// File: rtl/psl_pkg.sv
// rtl/psl_pkg.sv - shared types, job command constants and odd-parity helpers for the PSL-side driver
package psl_pkg;

    typedef enum logic [1:0] {
        OP_JRESET = 2'b00,
        OP_JSTART = 2'b01,
        OP_MMWR   = 2'b10,
        OP_MMRD   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        STAT_OK      = 2'b00,
        STAT_TIMEOUT = 2'b01,
        STAT_PARITY  = 2'b10
    } status_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_ISSUE = 2'b01,
        S_WAIT  = 2'b10,
        S_RESP  = 2'b11
    } state_e;

    localparam logic [7:0] JCOM_RESET = 8'h80;
    localparam logic [7:0] JCOM_START = 8'h90;

    typedef struct packed {
        logic [0:7]  com;
        logic        compar;
        logic [0:63] ea;
        logic        eapar;
    } job_cmd_t;

    typedef struct packed {
        logic        cfg;
        logic        rnw;
        logic        dw;
        logic [0:23] ad;
        logic        adpar;
        logic [0:63] data;
        logic        datapar;
    } mm_cmd_t;

    function automatic logic odd_par8(input logic [0:7] v);
        return ~^v;
    endfunction

    function automatic logic odd_par24(input logic [0:23] v);
        return ~^v;
    endfunction

    function automatic logic odd_par64(input logic [0:63] v);
        return ~^v;
    endfunction

endpackage

// File: rtl/psl_job_mmio_driver_if.sv
// rtl/psl_job_mmio_driver_if.sv - request/response port plus AFU job/MMIO wires seen by the driver
interface psl_job_mmio_driver_if;
    logic        req_valid;
    logic        req_ready;
    logic [0:1]  req_op;
    logic        req_cfg;
    logic        req_dw;
    logic [0:23] req_addr;
    logic [0:63] req_data;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [0:1]  rsp_status;
    logic [0:63] rsp_data;

    logic        ha_jval;
    logic [0:7]  ha_jcom;
    logic        ha_jcompar;
    logic [0:63] ha_jea;
    logic        ha_jeapar;

    logic        ha_mmval;
    logic        ha_mmcfg;
    logic        ha_mmrnw;
    logic        ha_mmdw;
    logic [0:23] ha_mmad;
    logic        ha_mmadpar;
    logic [0:63] ha_mmdata;
    logic        ha_mmdatapar;

    logic        ah_jrunning;
    logic        ah_jdone;
    logic        ah_mmack;
    logic [0:63] ah_mmdata;
    logic        ah_mmdatapar;
    logic        ah_paren;

    modport master (
        input  req_valid, req_op, req_cfg, req_dw, req_addr, req_data, rsp_ready,
        input  ah_jrunning, ah_jdone, ah_mmack, ah_mmdata, ah_mmdatapar, ah_paren,
        output req_ready, rsp_valid, rsp_status, rsp_data,
        output ha_jval, ha_jcom, ha_jcompar, ha_jea, ha_jeapar,
        output ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmad, ha_mmadpar, ha_mmdata, ha_mmdatapar
    );

    modport slave (
        output req_valid, req_op, req_cfg, req_dw, req_addr, req_data, rsp_ready,
        output ah_jrunning, ah_jdone, ah_mmack, ah_mmdata, ah_mmdatapar, ah_paren,
        input  req_ready, rsp_valid, rsp_status, rsp_data,
        input  ha_jval, ha_jcom, ha_jcompar, ha_jea, ha_jeapar,
        input  ha_mmval, ha_mmcfg, ha_mmrnw, ha_mmdw, ha_mmad, ha_mmadpar, ha_mmdata, ha_mmdatapar
    );
endinterface

// File: rtl/psl_timeout_counter.sv
// rtl/psl_timeout_counter.sv - WAIT-state cycle counter flagging the last allowed cycle
module psl_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Saturates at the last cycle so a stalled enable can never wrap back to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && !expired_o) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
endmodule

// File: rtl/psl_job_mmio_driver.sv
// rtl/psl_job_mmio_driver.sv - host-side initiator issuing one job/MMIO request at a time to the AFU
module psl_job_mmio_driver
    import psl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input logic                    ha_pclock,
    input logic                    ha_reset,
    psl_job_mmio_driver_if.master  bus
);
    state_e      state_q, state_d;
    op_e         op_q, op_d;
    job_cmd_t    job_q, job_d;
    mm_cmd_t     mm_q, mm_d;
    status_e     status_q, status_d;
    logic [0:63] rdata_q, rdata_d;

    logic is_mmio;
    logic afu_done;
    logic rd_par_bad;
    logic expired;

    assign is_mmio    = (op_q == OP_MMWR) || (op_q == OP_MMRD);
    assign afu_done   = ((op_q == OP_JRESET) && bus.ah_jdone)
                     || ((op_q == OP_JSTART) && bus.ah_jrunning)
                     || (is_mmio && bus.ah_mmack);
    assign rd_par_bad = bus.ah_paren && (bus.ah_mmdatapar != odd_par64(bus.ah_mmdata));

    psl_timeout_counter #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .CNT_W          (CNT_W)
    ) u_timeout (
        .clk_i     (ha_pclock),
        .rst_i     (ha_reset),
        .clear_i   (state_q == S_ISSUE),
        .enable_i  (state_q == S_WAIT),
        .expired_o (expired)
    );

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        job_d    = job_q;
        mm_d     = mm_q;
        status_d = status_q;
        rdata_d  = rdata_q;
        unique case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d    = op_e'(bus.req_op);
                    state_d = S_ISSUE;
                    // Only the field set of the accepted op is reloaded; the other bus keeps its last values.
                    if (!bus.req_op[0]) begin
                        job_d.com    = bus.req_op[1] ? JCOM_START : JCOM_RESET;
                        job_d.compar = odd_par8(job_d.com);
                        job_d.ea     = bus.req_data;
                        job_d.eapar  = odd_par64(bus.req_data);
                    end else begin
                        mm_d.cfg     = bus.req_cfg;
                        mm_d.rnw     = bus.req_op[0] & bus.req_op[1];
                        mm_d.dw      = bus.req_dw;
                        mm_d.ad      = bus.req_addr;
                        mm_d.adpar   = odd_par24(bus.req_addr);
                        mm_d.data    = bus.req_data;
                        mm_d.datapar = odd_par64(bus.req_data);
                    end
                end
            end
            S_ISSUE: state_d = S_WAIT;
            S_WAIT: begin
                if (afu_done) begin
                    state_d  = S_RESP;
                    status_d = (op_q == OP_MMRD && rd_par_bad) ? STAT_PARITY : STAT_OK;
                    rdata_d  = (op_q == OP_MMRD) ? bus.ah_mmdata : '0;
                end else if (expired) begin
                    state_d  = S_RESP;
                    status_d = STAT_TIMEOUT;
                    rdata_d  = '0;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge ha_pclock or posedge ha_reset) begin
        if (ha_reset) begin
            state_q  <= S_IDLE;
            op_q     <= OP_JRESET;
            job_q    <= '0;
            mm_q     <= '0;
            status_q <= STAT_OK;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            job_q    <= job_d;
            mm_q     <= mm_d;
            status_q <= status_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.req_ready    = (state_q == S_IDLE);
    assign bus.rsp_valid    = (state_q == S_RESP);
    assign bus.rsp_status   = status_q;
    assign bus.rsp_data     = rdata_q;
    assign bus.ha_jval      = (state_q == S_ISSUE) && !is_mmio;
    assign bus.ha_jcom      = job_q.com;
    assign bus.ha_jcompar   = job_q.compar;
    assign bus.ha_jea       = job_q.ea;
    assign bus.ha_jeapar    = job_q.eapar;
    assign bus.ha_mmval     = (state_q == S_ISSUE) && is_mmio;
    assign bus.ha_mmcfg     = mm_q.cfg;
    assign bus.ha_mmrnw     = mm_q.rnw;
    assign bus.ha_mmdw      = mm_q.dw;
    assign bus.ha_mmad      = mm_q.ad;
    assign bus.ha_mmadpar   = mm_q.adpar;
    assign bus.ha_mmdata    = mm_q.data;
    assign bus.ha_mmdatapar = mm_q.datapar;
endmodule
